// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stage enables, flushes,
// forwarding selects, memory-wait freeze with timeout abort, and a stall-cycle counter.
module pipeline_ctrl #(
  parameter int XADDR       = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [XADDR-1:0] i_ex_rs1_addr,
  input  logic [XADDR-1:0] i_ex_rs2_addr,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_ex_wr_en,
  input  logic             i_ex_is_load,
  input  logic             i_br_taken,
  input  logic [XADDR-1:0] i_mem_rd_addr,
  input  logic             i_mem_wr_en,
  input  logic             i_mem_req,
  input  logic             i_dmem_ready,
  input  logic [XADDR-1:0] i_wb_rd_addr,
  input  logic             i_wb_wr_en,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_id_byp_a,
  output logic             o_id_byp_b,
  output logic             o_mem_abort,
  output logic [1:0]       or_state,
  output logic             or_bus_err,
  output logic [31:0]      or_stall_cycles
);

  typedef enum logic [1:0] {
    S_RESET    = 2'b00,
    S_RUN      = 2'b01,
    S_MEM_WAIT = 2'b10
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic        w_timeout_hit;
  logic        w_freeze;
  logic        w_load_use;

  assign w_timeout_hit = (r_state == S_MEM_WAIT) && (r_wait_cnt == TO_LAST);
  assign w_freeze      = (r_state != S_RESET) && i_mem_req && !i_dmem_ready && !w_timeout_hit;
  assign w_load_use    = i_ex_is_load && i_ex_wr_en && (i_ex_rd_addr != '0) &&
                         ((i_id_uses_rs1 && (i_ex_rd_addr == i_id_rs1_addr)) ||
                          (i_id_uses_rs2 && (i_ex_rd_addr == i_id_rs2_addr)));

  // MEM result is younger than WB, so it wins; x0 is never forwarded
  always_comb begin
    o_fwd_a = 2'b00;
    o_fwd_b = 2'b00;
    if (i_mem_wr_en && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs1_addr))
      o_fwd_a = 2'b01;
    else if (i_wb_wr_en && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs1_addr))
      o_fwd_a = 2'b10;
    if (i_mem_wr_en && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs2_addr))
      o_fwd_b = 2'b01;
    else if (i_wb_wr_en && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs2_addr))
      o_fwd_b = 2'b10;
  end

  assign o_id_byp_a = i_wb_wr_en && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs1_addr);
  assign o_id_byp_b = i_wb_wr_en && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs2_addr);

  always_comb begin
    w_state_nxt  = r_state;
    o_mem_abort  = 1'b0;
    o_pc_en      = 1'b1;
    o_ifid_en    = 1'b1;
    o_idex_en    = 1'b1;
    o_exmem_en   = 1'b1;
    o_memwb_en   = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    case (r_state)
      S_RESET:    w_state_nxt = S_RUN;
      S_RUN:      if (w_freeze) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (i_dmem_ready || w_timeout_hit) w_state_nxt = S_RUN;
        o_mem_abort = w_timeout_hit;
      end
      default:    w_state_nxt = S_RESET;
    endcase
    // A held branch/hazard is acted on only once the freeze lifts
    if (r_state == S_RESET || w_freeze) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_en  = 1'b0;
      o_exmem_en = 1'b0;
      o_memwb_en = 1'b0;
      if (r_state == S_RESET) begin
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
      end
    end else if (i_br_taken) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_RESET;
      r_wait_cnt      <= '0;
      or_bus_err      <= 1'b0;
      or_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (r_state == S_MEM_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
      if (w_timeout_hit)
        or_bus_err <= 1'b1;
      if (!o_pc_en && (r_state != S_RESET) && (or_stall_cycles != 32'hFFFF_FFFF))
        or_stall_cycles <= or_stall_cycles + 32'd1;
    end
  end

  assign or_state = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expectations queued as each step is driven,
// then popped and checked with immediate assertions once outputs settle.
module tb_pipeline_ctrl;

  logic        i_clk, i_rst_n;
  logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr;
  logic [4:0]  i_mem_rd_addr, i_wb_rd_addr;
  logic        i_id_uses_rs1, i_id_uses_rs2, i_ex_wr_en, i_ex_is_load, i_br_taken;
  logic        i_mem_wr_en, i_mem_req, i_dmem_ready, i_wb_wr_en;
  logic        o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
  logic        o_ifid_flush, o_idex_flush, o_id_byp_a, o_id_byp_b, o_mem_abort, or_bus_err;
  logic [1:0]  o_fwd_a, o_fwd_b, or_state;
  logic [31:0] or_stall_cycles;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  pipeline_ctrl #(.XADDR(5), .MEM_TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_ex_rs1_addr(i_ex_rs1_addr), .i_ex_rs2_addr(i_ex_rs2_addr),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_wr_en(i_ex_wr_en), .i_ex_is_load(i_ex_is_load),
    .i_br_taken(i_br_taken), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_wr_en(i_mem_wr_en),
    .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
    .i_wb_rd_addr(i_wb_rd_addr), .i_wb_wr_en(i_wb_wr_en),
    .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_idex_en(o_idex_en),
    .o_exmem_en(o_exmem_en), .o_memwb_en(o_memwb_en),
    .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_id_byp_a(o_id_byp_a), .o_id_byp_b(o_id_byp_b),
    .o_mem_abort(o_mem_abort), .or_state(or_state), .or_bus_err(or_bus_err),
    .or_stall_cycles(or_stall_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic ex(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic ck(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed=%0h but no expected value queued", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  // Wait for the falling edge and return all inputs (except reset) to idle
  task automatic step();
    @(negedge i_clk);
    i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_uses_rs1 = 0; i_id_uses_rs2 = 0;
    i_ex_rs1_addr = '0; i_ex_rs2_addr = '0; i_ex_rd_addr = '0;
    i_ex_wr_en = 0; i_ex_is_load = 0; i_br_taken = 0;
    i_mem_rd_addr = '0; i_mem_wr_en = 0; i_mem_req = 0; i_dmem_ready = 0;
    i_wb_rd_addr = '0; i_wb_wr_en = 0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    step();
    step();
    ex(32'd0); ex(32'd0); ex(32'd0); ex(32'd0); ex(32'd1); ex(32'd1);
    #1;
    ck("rst_state", 32'(or_state)); ck("rst_bus_err", 32'(or_bus_err));
    ck("rst_stall", or_stall_cycles); ck("rst_pc_en", 32'(o_pc_en));
    ck("rst_ifid_flush", 32'(o_ifid_flush)); ck("rst_idex_flush", 32'(o_idex_flush));

    step(); i_rst_n = 1'b1;
    step();
    ex(32'd1); ex(32'd0); ex(32'd0); ex(32'd1); ex(32'd1); ex(32'd1); ex(32'd0);
    #1;
    ck("run_state", 32'(or_state)); ck("run_ifid_flush", 32'(o_ifid_flush));
    ck("run_idex_flush", 32'(o_idex_flush)); ck("run_pc_en", 32'(o_pc_en));
    ck("run_idex_en", 32'(o_idex_en)); ck("run_memwb_en", 32'(o_memwb_en));
    ck("run_stall", or_stall_cycles);

    // Load-use on rs1 = 5
    step();
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_uses_rs1 = 1;
    ex(32'd0); ex(32'd0); ex(32'd1); ex(32'd1); ex(32'd1);
    #1;
    ck("lu_pc_en", 32'(o_pc_en)); ck("lu_ifid_en", 32'(o_ifid_en));
    ck("lu_idex_flush", 32'(o_idex_flush)); ck("lu_idex_en", 32'(o_idex_en));
    ck("lu_exmem_en", 32'(o_exmem_en));

    step();
    i_wb_wr_en = 1; i_wb_rd_addr = 5'd5; i_ex_rs1_addr = 5'd5;
    ex(32'd2); ex(32'd1); ex(32'd1);
    #1;
    ck("lu_fwd_a", 32'(o_fwd_a)); ck("lu_stall", or_stall_cycles); ck("lu_after_pc_en", 32'(o_pc_en));

    // Load into x0 never stalls or forwards
    step();
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 5'd0; i_id_rs1_addr = 5'd0; i_id_uses_rs1 = 1;
    i_mem_wr_en = 1; i_mem_rd_addr = 5'd0; i_ex_rs1_addr = 5'd0;
    ex(32'd1); ex(32'd0); ex(32'd0);
    #1;
    ck("x0_pc_en", 32'(o_pc_en)); ck("x0_idex_flush", 32'(o_idex_flush)); ck("x0_fwd_a", 32'(o_fwd_a));

    // rs2 matches but is not used: no hazard
    step();
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 5'd7; i_id_rs2_addr = 5'd7; i_id_uses_rs2 = 0;
    ex(32'd1);
    #1;
    ck("nouse_pc_en", 32'(o_pc_en));

    // Forward priority MEM over WB, plus ID bypass
    step();
    i_mem_wr_en = 1; i_mem_rd_addr = 5'd3; i_wb_wr_en = 1; i_wb_rd_addr = 5'd3;
    i_ex_rs2_addr = 5'd3; i_id_rs1_addr = 5'd3;
    ex(32'd1); ex(32'd0); ex(32'd1); ex(32'd0);
    #1;
    ck("fwd_b_mem", 32'(o_fwd_b)); ck("fwd_a_none", 32'(o_fwd_a));
    ck("byp_a", 32'(o_id_byp_a)); ck("byp_b", 32'(o_id_byp_b));

    step();
    i_wb_wr_en = 1; i_wb_rd_addr = 5'd3; i_ex_rs2_addr = 5'd3;
    ex(32'd2);
    #1;
    ck("fwd_b_wb", 32'(o_fwd_b));

    // Memory wait: 4 frozen cycles, branch acted on at the ready cycle
    for (int i = 0; i < 4; i++) begin
      step();
      i_mem_req = 1; i_dmem_ready = 0; i_br_taken = 1;
      ex(32'd0); ex(32'd0); ex(32'd0); ex((i == 0) ? 32'd1 : 32'd2);
      #1;
      ck("mw_pc_en", 32'(o_pc_en)); ck("mw_memwb_en", 32'(o_memwb_en));
      ck("mw_ifid_flush", 32'(o_ifid_flush)); ck("mw_state", 32'(or_state));
    end
    step();
    i_mem_req = 1; i_dmem_ready = 1; i_br_taken = 1;
    ex(32'd2); ex(32'd1); ex(32'd1); ex(32'd1);
    #1;
    ck("mw_rdy_state", 32'(or_state)); ck("mw_rdy_pc_en", 32'(o_pc_en));
    ck("mw_rdy_ifid_flush", 32'(o_ifid_flush)); ck("mw_rdy_idex_flush", 32'(o_idex_flush));
    step();
    ex(32'd1); ex(32'd5);
    #1;
    ck("mw_end_state", 32'(or_state)); ck("mw_end_stall", or_stall_cycles);

    // Same-cycle ready: no freeze, no state change
    step();
    i_mem_req = 1; i_dmem_ready = 1;
    ex(32'd1);
    #1;
    ck("sc_pc_en", 32'(o_pc_en));
    step();
    ex(32'd1); ex(32'd5);
    #1;
    ck("sc_state", 32'(or_state)); ck("sc_stall", or_stall_cycles);

    // Timeout: 8 frozen cycles, abort on the 9th
    for (int i = 1; i <= 8; i++) begin
      step();
      i_mem_req = 1;
      ex(32'd0); ex(32'd0); ex(32'd0);
      #1;
      ck("to_pc_en", 32'(o_pc_en)); ck("to_abort", 32'(o_mem_abort)); ck("to_bus_err", 32'(or_bus_err));
    end
    step();
    i_mem_req = 1;
    ex(32'd1); ex(32'd1); ex(32'd2); ex(32'd0);
    #1;
    ck("to_abort_pulse", 32'(o_mem_abort)); ck("to_abort_pc_en", 32'(o_pc_en));
    ck("to_abort_state", 32'(or_state)); ck("to_abort_bus_err", 32'(or_bus_err));
    step();
    ex(32'd0); ex(32'd1); ex(32'd1); ex(32'd13);
    #1;
    ck("to_post_abort", 32'(o_mem_abort)); ck("to_post_bus_err", 32'(or_bus_err));
    ck("to_post_state", 32'(or_state)); ck("to_post_stall", or_stall_cycles);
    step();
    ex(32'd1);
    #1;
    ck("to_sticky", 32'(or_bus_err));

    // Reset asserted in the middle of a memory wait
    for (int i = 0; i < 3; i++) begin
      step();
      i_mem_req = 1;
    end
    step();
    i_mem_req = 1; i_rst_n = 1'b0;
    step();
    ex(32'd0); ex(32'd0); ex(32'd0); ex(32'd0); ex(32'd1);
    #1;
    ck("mrst_state", 32'(or_state)); ck("mrst_bus_err", 32'(or_bus_err));
    ck("mrst_stall", or_stall_cycles); ck("mrst_pc_en", 32'(o_pc_en)); ck("mrst_idex_flush", 32'(o_idex_flush));
    i_rst_n = 1'b1;
    step();
    ex(32'd1); ex(32'd1);
    #1;
    ck("mrst_run_state", 32'(or_state)); ck("mrst_run_pc_en", 32'(o_pc_en));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage RV32I pipeline (IF, ID, EX, MEM, WB). It sits beside the decode stage and does four things:
- generates stage enables and flushes;
- detects load-use hazards;
- selects EX-operand forwarding sources and the ID-stage writeback bypass;
- freezes the pipeline while data memory is busy, with a timeout that raises a sticky bus error.

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- XADDR, 5, register address width
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before abort (1..65535)

Ports:
- i_clk  in  1  CPU clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_id_rs1_addr, i_id_rs2_addr  in  XADDR  source registers of the instruction in ID
- i_id_uses_rs1, i_id_uses_rs2  in  1  ID instruction reads rs1/rs2
- i_ex_rs1_addr, i_ex_rs2_addr  in  XADDR  source registers held in the ID/EX register
- i_ex_rd_addr  in  XADDR  destination register of the EX instruction
- i_ex_wr_en  in  1  EX instruction writes rd
- i_ex_is_load  in  1  EX instruction is a load
- i_br_taken  in  1  EX resolved a taken branch, JAL or JALR (redirect)
- i_mem_rd_addr  in  XADDR  destination register of the MEM instruction
- i_mem_wr_en  in  1  MEM instruction writes rd
- i_mem_req  in  1  MEM stage has an active load/store
- i_dmem_ready  in  1  data memory completes the request this cycle
- i_wb_rd_addr  in  XADDR  writeback destination register
- i_wb_wr_en  in  1  writeback enable
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1  stage register enables
- o_ifid_flush, o_idex_flush  out  1  insert bubble (NOP, zero control) into IF/ID or ID/EX
- o_fwd_a, o_fwd_b  out  2  EX operand source: 00 regfile, 01 MEM result, 10 WB result
- o_id_byp_a, o_id_byp_b  out  1  ID uses i_wb data instead of register-file read
- o_mem_abort  out  1  one-cycle pulse: MEM request abandoned on timeout
- or_state  out  2  00 S_RESET, 01 S_RUN, 10 S_MEM_WAIT
- or_bus_err  out  1  sticky timeout flag
- or_stall_cycles  out  32  saturating count of stalled cycles

## Operation
**Combinational control** (same-cycle, from inputs and state):
- freeze = i_mem_req & ~i_dmem_ready & ~timeout_hit, in S_RUN or S_MEM_WAIT.
  - timeout_hit = (state == S_MEM_WAIT) & (wait_cnt == MEM_TIMEOUT-1).
- load_use = i_ex_is_load & i_ex_wr_en & (i_ex_rd_addr != 0) & ((i_id_uses_rs1 & rd == rs1) | (i_id_uses_rs2 & rd == rs2)).

**Priority:** S_RESET > freeze > i_br_taken > load_use > normal.
- S_RESET: all enables 0; both flushes 1.
- freeze: all enables 0; no flush. A pending branch or hazard is held and acted on at unfreeze.
- i_br_taken: all enables 1; o_ifid_flush = 1 and o_idex_flush = 1. The branch squashes any load-use-dependent instruction.
- load_use: o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1; the remaining enables are 1. This inserts exactly one bubble.
- normal: all enables 1; no flush.

**Forwarding:**
- o_fwd_a = 01 if i_mem_wr_en & i_mem_rd_addr != 0 & i_mem_rd_addr == i_ex_rs1_addr.
- Otherwise o_fwd_a = 10 if the same condition holds with the WB fields.
- Otherwise o_fwd_a = 00.
- MEM takes priority over WB. o_fwd_b is the same using i_ex_rs2_addr.
- o_id_byp_a/b = i_wb_wr_en & i_wb_rd_addr != 0 & i_wb_rd_addr == i_id_rs1/rs2_addr.
- The ID uses flags do not gate forwarding or bypass; x0 is never forwarded.

**State machine:**
- S_RESET → S_RUN after one cycle.
- S_RUN → S_MEM_WAIT when freeze.
- S_MEM_WAIT → S_RUN when i_dmem_ready, or when timeout_hit.
- On timeout_hit: o_mem_abort = 1, or_bus_err set to 1, no freeze that cycle.

**Counters:**
- wait_cnt clears on entry to S_MEM_WAIT and increments each cycle in it.
- or_stall_cycles increments, saturating at 32'hFFFF_FFFF, each cycle in which o_pc_en = 0 and state != S_RESET.

## Timing
- Reset: or_state = S_RESET, or_bus_err = 0, or_stall_cycles = 0, wait_cnt = 0. Combinational outputs then follow S_RESET.
- Reset asserted mid-S_MEM_WAIT returns to S_RESET next edge and clears all registered state.
- Enables and flushes have zero-cycle latency.
- or_state, or_bus_err and or_stall_cycles update on posedge i_clk.
- A request that is ready in the same cycle as i_mem_req causes no freeze and no state change.
- The abort cycle is the (MEM_TIMEOUT+1)-th cycle of the request. Exactly MEM_TIMEOUT frozen cycles precede it.
- or_bus_err clears only on reset.

## Test plan
- Reset release: i_rst_n low 2 cycles then high → cycle 1 after release or_state = 01, both flushes 0, all enables 1, or_stall_cycles = 0.
- Load-use: EX is a load with rd = 5, ID rs1 = 5, uses_rs1 = 1 → one cycle with o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1. Next cycle (load in WB): o_fwd_a = 10, or_stall_cycles = 1.
- Load-use on x0: EX load rd = 0, ID rs1 = 0 → no stall, o_fwd_a = 00.
- Forward priority: MEM rd = 3 and WB rd = 3 both write, EX rs2 = 3 → o_fwd_b = 01. Drop MEM write → 10.
- Memory wait: i_mem_req = 1 with i_dmem_ready low 4 cycles then high → 4 frozen cycles, or_state = 10 for 4 cycles, or_stall_cycles = 4. A concurrent i_br_taken produces its flushes only on the ready cycle.
- Timeout with MEM_TIMEOUT = 8 and i_dmem_ready never high → 8 frozen cycles, then o_mem_abort pulse, or_bus_err = 1 (stays set), or_state back to 01.
